// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Shared RV32I front-end types and constants. Holds the widest
//                supported PC width, the instruction width, the canonical NOP
//                and the prefetch entry layout {ir, pc}.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    // addi x0, x0, 0
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    // Narrower fetch PCs are zero-extended into the pc field.
    typedef struct packed {
        logic [INSTR_W-1:0] ir;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/rv32i_fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_fetch_queue_if
//  Description : Bundles the fetch front end's redirect input, instruction
//                memory request/response channels and the decode-side
//                valid/ready output channel.
//  Ports       : redir_valid/redir_pc        - branch redirect from EX
//                imem_req_valid/ready/addr   - fetch request channel
//                imem_rsp_valid/data         - in-order fetch responses
//                if_valid/ready/ir/pc/npc    - instruction handed to decode
//  Modports    : master - the fetch queue; slave - memory/decode/EX side
//  Revision    : 1.0 - initial release
// ============================================================================
interface rv32i_fetch_queue_if #(
    parameter int PC_W = 32
) ();

    logic                            redir_valid;
    logic [PC_W-1:0]                 redir_pc;

    logic                            imem_req_valid;
    logic                            imem_req_ready;
    logic [PC_W-1:0]                 imem_req_addr;
    logic                            imem_rsp_valid;
    logic [rv32i_pkg::INSTR_W-1:0]   imem_rsp_data;

    logic                            if_valid;
    logic                            if_ready;
    logic [rv32i_pkg::INSTR_W-1:0]   if_ir;
    logic [PC_W-1:0]                 if_pc;
    logic [PC_W-1:0]                 if_npc;

    modport master (
        input  redir_valid, redir_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output if_valid, if_ir, if_pc, if_npc,
        input  if_ready
    );

    modport slave (
        output redir_valid, redir_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  if_valid, if_ir, if_pc, if_npc,
        output if_ready
    );

endinterface
`default_nettype wire

// File: rtl/rv32i_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_fetch_fifo
//  Description : Synchronous prefetch FIFO of fetch entries with flush.
//                Head entry is presented combinationally; push and pop may
//                happen in the same cycle at any occupancy (no bypass, so a
//                pushed entry is visible the cycle after the push).
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                i_push/i_data  - write an entry
//                i_pop          - retire the head entry (ignored when empty)
//                i_flush        - discard all entries
//                o_data         - head entry
//                o_count        - occupancy, 0..DEPTH
//                o_full/o_empty - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  fetch_entry_t             i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output fetch_entry_t             o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int                  c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]    c_DEPTH = DEPTH[c_PTR_W:0];
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE = 1;

    fetch_entry_t          r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W:0]      r_count;
    logic                  w_do_pop;
    logic                  w_do_push;

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= r_count + {{c_PTR_W{1'b0}}, w_do_push}
                               - {{c_PTR_W{1'b0}}, w_do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !i_flush && w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == c_DEPTH);
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/rv32i_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_fetch_queue
//  Description : RV32I instruction-fetch front end. Issues sequential
//                word-indexed fetch requests under a credit limit, buffers
//                in-order responses in a prefetch FIFO and hands
//                {IR, PC, NPC} to decode. A redirect from EX flushes the
//                FIFO and drops every response still in flight.
//  Ports       : clk - clock
//                RN  - synchronous active-high reset
//                bus - rv32i_fetch_queue_if.master (redirect, IMEM request/
//                      response, decode output)
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_fetch_queue
    import rv32i_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  RN,
    rv32i_fetch_queue_if.master   bus
);

    localparam int                 c_CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W:0]   c_DEPTH_CNT = DEPTH[c_CNT_W:0];
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = 1;
    localparam logic [PC_W-1:0]    c_PC_ONE    = 1;

    logic [PC_W-1:0]      r_fetch_pc;
    logic [PC_W-1:0]      r_rsp_pc;
    logic [c_CNT_W-1:0]   r_outstanding;
    logic [c_CNT_W-1:0]   r_drop_cnt;

    logic [c_CNT_W-1:0]   w_fifo_count;
    logic [c_CNT_W-1:0]   w_outstanding_nxt;
    logic [c_CNT_W:0]     w_credit_used;
    logic                 w_req_valid;
    logic                 w_accept;
    logic                 w_rsp_drop;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_if_valid;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [PC_W-1:0]      w_if_pc;
    fetch_entry_t         w_push_entry;
    fetch_entry_t         w_head;

    // Requests in flight plus buffered entries never exceed DEPTH, so every
    // response is guaranteed a free FIFO slot.
    assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign w_req_valid   = !RN && !bus.redir_valid && (w_credit_used < c_DEPTH_CNT);
    assign w_accept      = w_req_valid && bus.imem_req_ready;

    assign w_outstanding_nxt = r_outstanding
                             + {{(c_CNT_W-1){1'b0}}, w_accept}
                             - {{(c_CNT_W-1){1'b0}}, bus.imem_rsp_valid};

    // A response landing in a redirect cycle belongs to the old path; it is
    // not counted in drop_cnt, so it must be discarded here instead.
    assign w_rsp_drop = (r_drop_cnt != '0);
    assign w_push     = !RN && bus.imem_rsp_valid && !w_rsp_drop && !bus.redir_valid;
    assign w_if_valid = !RN && !w_fifo_empty && !bus.redir_valid;
    assign w_pop      = w_if_valid && bus.if_ready;

    always_comb begin
        w_push_entry               = '0;
        w_push_entry.ir            = bus.imem_rsp_data;
        w_push_entry.pc[PC_W-1:0]  = r_rsp_pc;
    end

    always_ff @(posedge clk) begin
        if (RN) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            if (bus.redir_valid) begin
                r_fetch_pc <= bus.redir_pc;
                r_rsp_pc   <= bus.redir_pc;
                r_drop_cnt <= w_outstanding_nxt;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + c_PC_ONE;
                end
                if (bus.imem_rsp_valid) begin
                    if (w_rsp_drop) begin
                        r_drop_cnt <= r_drop_cnt - c_CNT_ONE;
                    end else begin
                        r_rsp_pc <= r_rsp_pc + c_PC_ONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RN) begin
            assert ({1'b0, r_outstanding} <= c_DEPTH_CNT);
            assert (r_drop_cnt <= r_outstanding);
            assert (!(w_push && w_fifo_full && !w_pop));
        end
    end

    rv32i_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (RN),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (bus.redir_valid),
        .o_data  (w_head),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_if_pc = w_head.pc[PC_W-1:0];

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.if_valid       = w_if_valid;
    // Decode sees a NOP rather than stale storage while the queue is empty.
    assign bus.if_ir          = w_fifo_empty ? NOP_INSTR : w_head.ir;
    assign bus.if_pc          = w_if_pc;
    assign bus.if_npc         = w_if_pc + c_PC_ONE;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32i_fetch_queue
//  Description : Directed self-checking bench for rv32i_fetch_queue with an
//                8-bit PC, DEPTH 4, RESET_PC 10 and a fixed-latency in-order
//                instruction memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_fetch_queue;

    localparam int PCW = 8;

    logic clk = 1'b0;
    logic RN;
    always #5 clk = ~clk;

    rv32i_fetch_queue_if #(.PC_W(PCW)) bus ();

    rv32i_fetch_queue #(
        .PC_W     (PCW),
        .DEPTH    (4),
        .RESET_PC (8'd10)
    ) dut (
        .clk (clk),
        .RN  (RN),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int lat      = 1;
    int cyc      = 0;

    typedef struct {
        logic [7:0] addr;
        int         due;
    } pend_t;

    pend_t       pend[$];
    logic [7:0]  acc_log[$];
    logic [7:0]  dlv_pc[$];
    logic [7:0]  dlv_npc[$];
    logic [31:0] dlv_ir[$];

    function automatic logic [31:0] idata(input logic [7:0] a);
        return 32'hC0DE_0000 | {24'h0, a};
    endfunction

    function automatic logic [7:0] qpc(input int i);
        return (i < dlv_pc.size()) ? dlv_pc[i] : 8'hxx;
    endfunction

    function automatic logic [7:0] qnpc(input int i);
        return (i < dlv_npc.size()) ? dlv_npc[i] : 8'hxx;
    endfunction

    function automatic logic [31:0] qir(input int i);
        return (i < dlv_ir.size()) ? dlv_ir[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [7:0] qacc(input int i);
        return (i < acc_log.size()) ? acc_log[i] : 8'hxx;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // IMEM model and monitors, evaluated mid-cycle while everything is stable.
    always @(negedge clk) begin
        if (RN) begin
            pend.delete();
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end else begin
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = idata(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = '0;
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                pend.push_back('{bus.imem_req_addr, cyc + lat});
                acc_log.push_back(bus.imem_req_addr);
            end
            if (bus.if_valid && bus.if_ready) begin
                dlv_pc.push_back(bus.if_pc);
                dlv_npc.push_back(bus.if_npc);
                dlv_ir.push_back(bus.if_ir);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_log.delete();
        dlv_pc.delete();
        dlv_npc.delete();
        dlv_ir.delete();
    endtask

    // Leaves the bench at the start of the first cycle out of reset.
    task automatic do_reset(input int l, input logic ifr, input logic rqr);
        RN                 = 1'b1;
        bus.redir_valid    = 1'b0;
        bus.redir_pc       = '0;
        bus.if_ready       = ifr;
        bus.imem_req_ready = rqr;
        lat                = l;
        tick();
        tick();
        RN = 1'b0;
        clear_logs();
    endtask

    task automatic redirect(input logic [7:0] pc);
        bus.redir_valid = 1'b1;
        bus.redir_pc    = pc;
        tick();
        bus.redir_valid = 1'b0;
    endtask

    task automatic test_reset();
        RN                 = 1'b1;
        bus.redir_valid    = 1'b0;
        bus.redir_pc       = '0;
        bus.if_ready       = 1'b1;
        bus.imem_req_ready = 1'b1;
        lat                = 1;
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if (bus.imem_req_valid !== 1'b0)
            $display("FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid);
        else n_pass++;
        n_checks++;
        if (bus.if_valid !== 1'b0)
            $display("FAIL reset_if_valid: got %b expected 0", bus.if_valid);
        else n_pass++;
        tick();
        RN = 1'b0;
        clear_logs();
        @(negedge clk);
        n_checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 8'd10)
            $display("FAIL reset_first_req: got valid=%b addr=%0d expected valid=1 addr=10",
                     bus.imem_req_valid, bus.imem_req_addr);
        else n_pass++;
    endtask

    // Continues from test_reset: cycle 0 has just been sampled.
    task automatic test_stream();
        logic [7:0] e;
        tick();
        @(negedge clk);
        n_checks++;
        if (bus.if_valid !== 1'b0)
            $display("FAIL stream_latency: got if_valid=%b expected 0 one cycle after first request",
                     bus.if_valid);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            e = 8'(10 + i);
            n_checks++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== e || bus.if_npc !== 8'(e + 8'd1)
                || bus.if_ir !== idata(e))
                $display("FAIL stream_out[%0d]: got v=%b pc=%0d npc=%0d ir=%h expected v=1 pc=%0d npc=%0d ir=%h",
                         i, bus.if_valid, bus.if_pc, bus.if_npc, bus.if_ir, e, 8'(e + 8'd1), idata(e));
            else n_pass++;
            n_checks++;
            if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 8'(e + 8'd2))
                $display("FAIL stream_req[%0d]: got v=%b addr=%0d expected v=1 addr=%0d",
                         i, bus.imem_req_valid, bus.imem_req_addr, 8'(e + 8'd2));
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        do_reset(1, 1'b0, 1'b1);
        repeat (10) tick();
        @(negedge clk);
        n_checks++;
        if (acc_log.size() !== 4)
            $display("FAIL bp_req_count: got %0d expected 4", acc_log.size());
        else n_pass++;
        n_checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.if_valid !== 1'b1 || bus.if_pc !== 8'd10)
            $display("FAIL bp_stalled: got req_v=%b if_v=%b pc=%0d expected req_v=0 if_v=1 pc=10",
                     bus.imem_req_valid, bus.if_valid, bus.if_pc);
        else n_pass++;
        tick();
        bus.if_ready = 1'b1;
        repeat (8) tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (qpc(i) !== 8'(10 + i) || qir(i) !== idata(8'(10 + i)))
                $display("FAIL bp_drain[%0d]: got pc=%0d ir=%h expected pc=%0d ir=%h",
                         i, qpc(i), qir(i), 8'(10 + i), idata(8'(10 + i)));
            else n_pass++;
        end
    endtask

    task automatic test_redirect();
        do_reset(3, 1'b1, 1'b0);
        redirect(8'd20);
        bus.imem_req_ready = 1'b1;
        tick();
        tick();
        bus.imem_req_ready = 1'b0;
        bus.redir_valid    = 1'b1;
        bus.redir_pc       = 8'd30;
        @(negedge clk);
        n_checks++;
        if (acc_log.size() !== 2 || qacc(0) !== 8'd20 || qacc(1) !== 8'd21)
            $display("FAIL redir_inflight: got n=%0d a0=%0d a1=%0d expected n=2 a0=20 a1=21",
                     acc_log.size(), qacc(0), qacc(1));
        else n_pass++;
        n_checks++;
        if (bus.if_valid !== 1'b0 || bus.imem_req_valid !== 1'b0)
            $display("FAIL redir_cycle: got if_v=%b req_v=%b expected 0 0",
                     bus.if_valid, bus.imem_req_valid);
        else n_pass++;
        tick();
        bus.redir_valid    = 1'b0;
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 8'd30)
            $display("FAIL redir_next_req: got v=%b addr=%0d expected v=1 addr=30",
                     bus.imem_req_valid, bus.imem_req_addr);
        else n_pass++;
        repeat (8) tick();
        n_checks++;
        if (qpc(0) !== 8'd30 || qpc(1) !== 8'd31 || qir(0) !== idata(8'd30))
            $display("FAIL redir_first_out: got pc0=%0d pc1=%0d ir0=%h expected pc0=30 pc1=31 ir0=%h",
                     qpc(0), qpc(1), qir(0), idata(8'd30));
        else n_pass++;
    endtask

    task automatic test_ready_stall();
        do_reset(1, 1'b1, 1'b0);
        redirect(8'd40);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 8'd40)
                $display("FAIL stall_hold[%0d]: got v=%b addr=%0d expected v=1 addr=40",
                         i, bus.imem_req_valid, bus.imem_req_addr);
            else n_pass++;
            tick();
        end
        bus.imem_req_ready = 1'b1;
        repeat (6) tick();
        n_checks++;
        if (qacc(0) !== 8'd40 || qacc(1) !== 8'd41 || qacc(2) !== 8'd42 || qacc(3) !== 8'd43)
            $display("FAIL stall_accepts: got %0d,%0d,%0d,%0d expected 40,41,42,43",
                     qacc(0), qacc(1), qacc(2), qacc(3));
        else n_pass++;
        n_checks++;
        if (qpc(0) !== 8'd40 || qpc(1) !== 8'd41 || qpc(2) !== 8'd42)
            $display("FAIL stall_deliver: got %0d,%0d,%0d expected 40,41,42",
                     qpc(0), qpc(1), qpc(2));
        else n_pass++;
    endtask

    // Redirect lands while a response arrives and the FIFO holds an entry.
    task automatic test_coincident();
        do_reset(2, 1'b1, 1'b1);
        repeat (6) tick();
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 8'd100;
        clear_logs();
        @(negedge clk);
        n_checks++;
        if (bus.if_valid !== 1'b0 || bus.imem_req_valid !== 1'b0)
            $display("FAIL coinc_cycle: got if_v=%b req_v=%b expected 0 0",
                     bus.if_valid, bus.imem_req_valid);
        else n_pass++;
        tick();
        bus.redir_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 8'd100)
            $display("FAIL coinc_next_req: got v=%b addr=%0d expected v=1 addr=100",
                     bus.imem_req_valid, bus.imem_req_addr);
        else n_pass++;
        repeat (8) tick();
        n_checks++;
        if (qpc(0) !== 8'd100 || qpc(1) !== 8'd101 || qir(0) !== idata(8'd100))
            $display("FAIL coinc_deliver: got pc0=%0d pc1=%0d ir0=%h expected pc0=100 pc1=101 ir0=%h",
                     qpc(0), qpc(1), qir(0), idata(8'd100));
        else n_pass++;
    endtask

    task automatic test_wrap_and_reset();
        do_reset(1, 1'b1, 1'b1);
        redirect(8'd254);
        repeat (5) tick();
        n_checks++;
        if (qpc(0) !== 8'd254 || qpc(1) !== 8'd255 || qpc(2) !== 8'd0)
            $display("FAIL wrap_pc: got %0d,%0d,%0d expected 254,255,0",
                     qpc(0), qpc(1), qpc(2));
        else n_pass++;
        n_checks++;
        if (qnpc(0) !== 8'd255 || qnpc(1) !== 8'd0 || qnpc(2) !== 8'd1)
            $display("FAIL wrap_npc: got %0d,%0d,%0d expected 255,0,1",
                     qnpc(0), qnpc(1), qnpc(2));
        else n_pass++;
        RN = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.if_valid !== 1'b0 || bus.imem_req_valid !== 1'b0)
            $display("FAIL midrst_during: got if_v=%b req_v=%b expected 0 0",
                     bus.if_valid, bus.imem_req_valid);
        else n_pass++;
        tick();
        RN = 1'b0;
        clear_logs();
        @(negedge clk);
        n_checks++;
        if (bus.if_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 8'd10)
            $display("FAIL midrst_restart: got if_v=%b req_v=%b addr=%0d expected 0 1 10",
                     bus.if_valid, bus.imem_req_valid, bus.imem_req_addr);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if (bus.if_valid !== 1'b0)
            $display("FAIL midrst_residue: got if_valid=%b expected 0", bus.if_valid);
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if (qpc(0) !== 8'd10 || qpc(1) !== 8'd11)
            $display("FAIL midrst_deliver: got %0d,%0d expected 10,11", qpc(0), qpc(1));
        else n_pass++;
    endtask

    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_ready_stall();
        test_coincident();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
